minibus_slave_regfile: RTL and testbench
========================================

Name: minibus_slave_regfile

Overview:
- Parametrised Mini-Bus slave register file; successor to the fixed 4-entry generic register array.
- Adds per-register access modes: RW, read-only hardware status, and write-1-to-clear sticky status with hardware set.
- Adds configurable wait states, address, alignment and width error checks, and per-register write strobes.
- Sits behind the Mini-Bus decoder. Peripherals use it as their control/status register bank.

Parameters:
- REGS_COUNT, 4: number of 32-bit registers; >= 1.
- ADDR_WIDTH, 8: byte-address width; must satisfy 2^(ADDR_WIDTH-2) >= REGS_COUNT.
- WAIT_STATES, 0: extra cycles inserted between accept and ack; 0..15.
- RO_MASK, '0: REGS_COUNT bits; bit i=1 makes register i read-only, returning hw_in[i].
- W1C_MASK, '0: REGS_COUNT bits; bit i=1 makes register i write-1-to-clear with hw_set. RO_MASK has priority if both bits are set.
- RESET_VAL, '0: REGS_COUNT*32 bits; reset value of each storage register.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- sel  in  1  slave selected by the decoder.
- wen  in  1  write request.
- ren  in  1  read request.
- addr  in  ADDR_WIDTH  byte address.
- width  in  2  00 byte, 01 half, 10 word, 11 illegal.
- wdata  in  32  write data, byte-lane aligned (byte in [7:0], half in [15:0]).
- ack  out  1  response valid, one-cycle pulse.
- err  out  1  error flag; valid only while ack=1.
- rdata  out  32  read data; valid only while ack=1 on a read, otherwise 0.
- regs_out  out  REGS_COUNT*32  current storage contents. RO entries drive 0.
- hw_in  in  REGS_COUNT*32  status inputs sampled for RO registers.
- hw_set  in  REGS_COUNT*32  per-bit set pulses for W1C registers; ignored for other modes.
- wr_pulse  out  REGS_COUNT  one-cycle strobe when register i is written without error.

Behaviour:
- Reset (rst=1 at a clk edge):
  - State returns to IDLE and the wait counter goes to 0.
  - ack=0, err=0, rdata=0, wr_pulse=0.
  - Storage is loaded from RESET_VAL.
  - Reset applies mid-transaction: the pending ack is dropped.
- FSM states:
  - IDLE: accept when sel && (wen || ren). Go to WAIT if WAIT_STATES>0, else to RESP.
  - WAIT: count down WAIT_STATES cycles, then go to RESP.
  - RESP: ack=1 for exactly one cycle, then IDLE.
  - Accept at edge T gives ack during cycle T+1+WAIT_STATES.
  - Back-to-back requests: the earliest next accept is the edge ending the first IDLE cycle after RESP.
- Master holds the request stable until ack. The slave ignores request inputs outside IDLE.
- If sel deasserts in WAIT or RESP, the transaction is aborted:
  - Go to IDLE with no ack.
  - A write already committed stays committed.
- Index = addr[ADDR_WIDTH-1:2].
- Error conditions are evaluated at accept. Any error means no storage update, no wr_pulse, and err=1 with ack. Errors:
  - wen && ren.
  - width == 11.
  - Index >= REGS_COUNT.
  - Misaligned access: half with addr[0]=1, or word with addr[1:0]!=0.
  - Write to an RO register.
- Write commit happens at the accept edge and is visible on regs_out from T+1.
  - Lane merge: byte writes replace lane addr[1:0]; half writes replace halves by addr[1]; word writes replace all 32 bits.
  - RW registers: storage is replaced by the merged value.
  - W1C registers: bits in the written lanes where wdata=1 are cleared. Other bits are unchanged.
  - wr_pulse[index]=1 in cycle T+1 only.
- hw_set on a W1C register sets the bits every cycle, independent of the bus.
  - Set and clear on the same bit in the same cycle: set wins (bit=1).
  - Not gated by rst? No: rst has priority over everything.
- Reads: data is captured at accept into a holding register.
  - RO registers capture hw_in[index]; others capture storage.
  - rdata returns the full aligned word regardless of width; the master extracts lanes.
  - rdata=0 when err=1 or ack=0.

Test Plan:
- Reset with RESET_VAL[1]=0xA5A5_0000, then word read addr 0x04 with WAIT_STATES=0 -> ack one cycle after accept, rdata=0xA5A5_0000, err=0.
- Reg0=0x1122_3344, byte write addr 0x02 wdata=0xEE -> regs_out[0]=0x11EE_3344 next cycle, wr_pulse[0]=1 for one cycle.
- WAIT_STATES=3, word write addr 0x00 -> ack exactly 4 cycles after accept. Repeat with half write addr 0x01 -> err=1, reg unchanged, no wr_pulse.
- W1C reg2=0x0000_00FF, write 0x0F to addr 0x08 while hw_set[2] bit0=1 in the same cycle -> reg2=0x0000_00F1.
- RO reg3 with hw_in[3]=0xDEAD_BEEF: read addr 0x0C -> rdata=0xDEAD_BEEF. Write to it -> err=1. Read addr 0x10 with REGS_COUNT=4 -> err=1, rdata=0.
- Assert rst during WAIT, and drop sel during WAIT -> no ack in either case. Storage equals RESET_VAL after rst. Next request is accepted normally.

Source files
------------

// File: rtl/minibus_slave_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : minibus_slave_regfile
//  Description : Parametrised Mini-Bus slave register bank. Each 32-bit
//                register is either read/write, read-only (returns hw_in),
//                or write-1-to-clear sticky status with hardware set.
//                Optional wait states between accept and ack; address,
//                alignment, width and access-mode error detection.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                sel/wen/ren     - request qualifiers from the decoder/master
//                addr/width      - byte address and access size
//                wdata           - lane-aligned write data
//                ack/err/rdata   - one-cycle response
//                regs_out        - storage contents (RO entries read as 0)
//                hw_in/hw_set    - status inputs / sticky-set pulses
//                wr_pulse        - per-register write strobe
//  Revision    : 1.0 - initial release
// ============================================================================
module minibus_slave_regfile #(
    parameter int                        REGS_COUNT  = 4,
    parameter int                        ADDR_WIDTH  = 8,
    parameter int                        WAIT_STATES = 0,
    parameter logic [REGS_COUNT-1:0]     RO_MASK     = '0,
    parameter logic [REGS_COUNT-1:0]     W1C_MASK    = '0,
    parameter logic [REGS_COUNT*32-1:0]  RESET_VAL   = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sel,
    input  logic                     wen,
    input  logic                     ren,
    input  logic [ADDR_WIDTH-1:0]    addr,
    input  logic [1:0]               width,
    input  logic [31:0]              wdata,
    output logic                     ack,
    output logic                     err,
    output logic [31:0]              rdata,
    output logic [REGS_COUNT*32-1:0] regs_out,
    input  logic [REGS_COUNT*32-1:0] hw_in,
    input  logic [REGS_COUNT*32-1:0] hw_set,
    output logic [REGS_COUNT-1:0]    wr_pulse
);

    localparam int         c_IDX_W     = ADDR_WIDTH - 2;
    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_WAIT   = 2'd1;
    localparam logic [1:0] c_ST_RESP   = 2'd2;
    // Counter is preloaded with WAIT_STATES-1 so WAIT lasts exactly WAIT_STATES cycles.
    localparam logic [3:0] c_WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    logic [1:0]               r_state;
    logic [3:0]               r_wait_cnt;
    logic                     r_err;
    logic [31:0]              r_rdata_hold;
    logic [REGS_COUNT-1:0]    r_wr_pulse;

    logic [c_IDX_W-1:0]       w_idx;
    logic [31:0]              w_idx_ext;
    logic                     w_in_range;
    logic                     w_misalign;
    logic                     w_ro_hit;
    logic                     w_err;
    logic                     w_accept;
    logic                     w_wr_ok;
    logic [31:0]              w_rd_word;
    logic [31:0]              w_lane;
    logic [31:0]              w_wsh;
    logic [REGS_COUNT*32-1:0] w_store;
    logic [REGS_COUNT-1:0]    w_hit_vec;

    assign w_idx      = addr[ADDR_WIDTH-1:2];
    assign w_idx_ext  = 32'(w_idx);
    assign w_in_range = (w_idx_ext < 32'(REGS_COUNT));
    assign w_misalign = ((width == 2'b01) && addr[0]) ||
                        ((width == 2'b10) && (addr[1:0] != 2'b00));

    // Register lookup by index; out-of-range indices fall through to zero.
    always_comb begin
        w_rd_word = '0;
        w_ro_hit  = 1'b0;
        for (int k = 0; k < REGS_COUNT; k++) begin
            if (w_idx_ext == 32'(k)) begin
                w_ro_hit  = RO_MASK[k];
                w_rd_word = RO_MASK[k] ? hw_in[k*32 +: 32] : w_store[k*32 +: 32];
            end
        end
    end

    assign w_err    = (wen && ren) || (width == 2'b11) || !w_in_range ||
                      w_misalign || (wen && w_ro_hit);
    assign w_accept = (r_state == c_ST_IDLE) && sel && (wen || ren);
    assign w_wr_ok  = w_accept && wen && !w_err;

    // Move the lane-aligned write data into its byte position and build the lane mask.
    always_comb begin
        w_lane = 32'hFFFF_FFFF;
        w_wsh  = wdata;
        case (width)
            2'b00: begin
                w_lane = 32'h0000_00FF << {addr[1:0], 3'b000};
                w_wsh  = {24'h0, wdata[7:0]} << {addr[1:0], 3'b000};
            end
            2'b01: begin
                w_lane = addr[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
                w_wsh  = addr[1] ? {wdata[15:0], 16'h0} : {16'h0, wdata[15:0]};
            end
            default: begin
                w_lane = 32'hFFFF_FFFF;
                w_wsh  = wdata;
            end
        endcase
    end

    genvar i;
    generate
        for (i = 0; i < REGS_COUNT; i++) begin : g_reg
            localparam bit c_RO  = RO_MASK[i];
            localparam bit c_W1C = W1C_MASK[i] && !RO_MASK[i];

            logic [31:0] r_reg;
            logic [31:0] w_next;
            logic        w_hit;

            assign w_hit = w_wr_ok && (w_idx_ext == 32'(i));

            // Hardware set is applied after the bus clear so a simultaneous set wins.
            always_comb begin
                w_next = r_reg;
                if (w_hit) begin
                    w_next = c_W1C ? (r_reg & ~(w_lane & w_wsh))
                                   : ((r_reg & ~w_lane) | (w_wsh & w_lane));
                end
                if (c_W1C) begin
                    w_next = w_next | hw_set[i*32 +: 32];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_reg <= RESET_VAL[i*32 +: 32];
                end else begin
                    r_reg <= w_next;
                end
            end

            assign w_store[i*32 +: 32]  = r_reg;
            assign regs_out[i*32 +: 32] = c_RO ? 32'h0 : r_reg;
            assign w_hit_vec[i]         = w_hit;
        end
    endgenerate

    // Transaction sequencer. Write commit and read capture happen at accept;
    // the later states only time the response.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_wait_cnt   <= 4'd0;
            r_err        <= 1'b0;
            r_rdata_hold <= '0;
            r_wr_pulse   <= '0;
        end else begin
            r_wr_pulse <= '0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_err        <= w_err;
                        r_rdata_hold <= (ren && !w_err) ? w_rd_word : 32'h0;
                        r_wr_pulse   <= w_hit_vec;
                        r_wait_cnt   <= c_WAIT_LOAD;
                        r_state      <= (WAIT_STATES > 0) ? c_ST_WAIT : c_ST_RESP;
                    end
                end
                c_ST_WAIT: begin
                    if (!sel) begin
                        r_state <= c_ST_IDLE;
                    end else if (r_wait_cnt == 4'd0) begin
                        r_state <= c_ST_RESP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 4'd1;
                    end
                end
                c_ST_RESP: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign ack      = (r_state == c_ST_RESP);
    assign err      = ack && r_err;
    assign rdata    = ack ? r_rdata_hold : 32'h0;
    assign wr_pulse = r_wr_pulse;

endmodule
`default_nettype wire

// File: tb/tb_minibus_slave_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : tb_minibus_slave_regfile
//  Description : Self-checking bench for minibus_slave_regfile. Two instances:
//                one without wait states, one with three. Both share the bus
//                lines and differ only in their select.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_minibus_slave_regfile;

    localparam int RC = 4;
    localparam int AW = 8;
    localparam logic [RC*32-1:0] c_RV = {32'h1234_5678, 32'h0000_00FF,
                                         32'hA5A5_0000, 32'h1122_3344};

    logic           clk = 1'b0;
    logic           rst;
    logic           sel0, sel3, wen, ren;
    logic [AW-1:0]  addr;
    logic [1:0]     width;
    logic [31:0]    wdata;
    logic [RC*32-1:0] hw_in, hw_set;
    logic           ack0, err0, ack3, err3;
    logic [31:0]    rdata0, rdata3;
    logic [RC*32-1:0] regs0, regs3;
    logic [RC-1:0]  pulse0, pulse3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    minibus_slave_regfile #(
        .REGS_COUNT(RC), .ADDR_WIDTH(AW), .WAIT_STATES(0),
        .RO_MASK(4'b1000), .W1C_MASK(4'b0100), .RESET_VAL(c_RV)
    ) u_dut0 (
        .clk(clk), .rst(rst), .sel(sel0), .wen(wen), .ren(ren), .addr(addr),
        .width(width), .wdata(wdata), .ack(ack0), .err(err0), .rdata(rdata0),
        .regs_out(regs0), .hw_in(hw_in), .hw_set(hw_set), .wr_pulse(pulse0)
    );

    minibus_slave_regfile #(
        .REGS_COUNT(RC), .ADDR_WIDTH(AW), .WAIT_STATES(3),
        .RO_MASK(4'b1000), .W1C_MASK(4'b0100), .RESET_VAL(c_RV)
    ) u_dut3 (
        .clk(clk), .rst(rst), .sel(sel3), .wen(wen), .ren(ren), .addr(addr),
        .width(width), .wdata(wdata), .ack(ack3), .err(err3), .rdata(rdata3),
        .regs_out(regs3), .hw_in(hw_in), .hw_set(hw_set), .wr_pulse(pulse3)
    );

    typedef struct {
        int          which;      // 0: no wait states, 1: three wait states
        logic        wen, ren;
        logic [7:0]  addr;
        logic [1:0]  width;
        logic [31:0] wdata;
        logic [31:0] hwset2;     // hw_set for register 2 during the accept edge
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic [3:0]  exp_pulse;
        int          reg_idx;
        logic [31:0] exp_reg;
    } vec_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    function automatic logic get_ack(int w);
        return (w != 0) ? ack3 : ack0;
    endfunction
    function automatic logic get_err(int w);
        return (w != 0) ? err3 : err0;
    endfunction
    function automatic logic [31:0] get_rdata(int w);
        return (w != 0) ? rdata3 : rdata0;
    endfunction
    function automatic logic [3:0] get_pulse(int w);
        return (w != 0) ? pulse3 : pulse0;
    endfunction
    function automatic logic [31:0] get_reg(int w, int idx);
        logic [RC*32-1:0] r;
        r = (w != 0) ? regs3 : regs0;
        return r[idx*32 +: 32];
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic idle_bus();
        sel0 = 1'b0; sel3 = 1'b0; wen = 1'b0; ren = 1'b0;
        addr = '0; width = 2'b10; wdata = '0;
    endtask

    task automatic do_txn(input vec_t v, input string nm);
        int   ws;
        logic got;
        exp_t e;
        ws = (v.which != 0) ? 3 : 0;
        sb.push_back('{err: v.exp_err, rdata: v.exp_rdata});
        @(negedge clk);
        wen = v.wen; ren = v.ren; addr = v.addr; width = v.width; wdata = v.wdata;
        hw_set = {32'h0, v.hwset2, 64'h0};
        sel0 = (v.which == 0); sel3 = (v.which != 0);
        got = 1'b0;
        for (int cyc = 1; cyc <= 30 && !got; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                hw_set = '0;
                chk({nm, "_pulse"}, get_pulse(v.which), v.exp_pulse);
            end
            if (get_ack(v.which)) begin
                got = 1'b1;
                e = sb.pop_front();
                chk({nm, "_lat"}, cyc, 1 + ws);
                chk({nm, "_err"}, get_err(v.which), e.err);
                chk({nm, "_rdata"}, get_rdata(v.which), e.rdata);
                chk({nm, "_reg"}, get_reg(v.which, v.reg_idx), v.exp_reg);
            end
        end
        if (!got) begin
            checks++; failures++;
            $display("FAIL %s_timeout actual=no_ack required=ack", nm);
            void'(sb.pop_front());
        end
        @(posedge clk); #1;
        idle_bus();
        @(negedge clk);
        chk({nm, "_ackpulse"}, get_ack(v.which), 1'b0);
    endtask

    // Watches a select line for any ack over a fixed window.
    task automatic watch_no_ack(input int w, input string nm);
        logic seen;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (get_ack(w)) seen = 1'b1;
        end
        chk(nm, seen, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        hw_in = {32'hDEAD_BEEF, 96'h0};
        hw_set = '0;
        idle_bus();

        //               which wen  ren  addr   wid    wdata         hwset2  err  rdata         pulse  idx reg
        vecs.push_back('{0, 1'b0, 1'b1, 8'h04, 2'b10, 32'h0,         32'h0, 1'b0, 32'hA5A5_0000, 4'b0000, 1, 32'hA5A5_0000});
        vecs.push_back('{0, 1'b1, 1'b0, 8'h02, 2'b00, 32'h0000_00EE, 32'h0, 1'b0, 32'h0,         4'b0001, 0, 32'h11EE_3344});
        vecs.push_back('{0, 1'b0, 1'b1, 8'h00, 2'b10, 32'h0,         32'h0, 1'b0, 32'h11EE_3344, 4'b0000, 0, 32'h11EE_3344});
        vecs.push_back('{0, 1'b0, 1'b1, 8'h0C, 2'b10, 32'h0,         32'h0, 1'b0, 32'hDEAD_BEEF, 4'b0000, 3, 32'h0});
        vecs.push_back('{0, 1'b1, 1'b0, 8'h0C, 2'b10, 32'hFFFF_FFFF, 32'h0, 1'b1, 32'h0,         4'b0000, 3, 32'h0});
        vecs.push_back('{0, 1'b0, 1'b1, 8'h10, 2'b10, 32'h0,         32'h0, 1'b1, 32'h0,         4'b0000, 0, 32'h11EE_3344});
        vecs.push_back('{0, 1'b0, 1'b1, 8'h00, 2'b11, 32'h0,         32'h0, 1'b1, 32'h0,         4'b0000, 0, 32'h11EE_3344});
        vecs.push_back('{0, 1'b1, 1'b1, 8'h00, 2'b10, 32'h0,         32'h0, 1'b1, 32'h0,         4'b0000, 0, 32'h11EE_3344});
        vecs.push_back('{0, 1'b1, 1'b0, 8'h06, 2'b01, 32'h0000_1234, 32'h0, 1'b0, 32'h0,         4'b0010, 1, 32'h1234_0000});
        vecs.push_back('{0, 1'b0, 1'b1, 8'h05, 2'b00, 32'h0,         32'h0, 1'b0, 32'h1234_0000, 4'b0000, 1, 32'h1234_0000});
        vecs.push_back('{0, 1'b1, 1'b0, 8'h08, 2'b10, 32'h0000_000F, 32'h1, 1'b0, 32'h0,         4'b0100, 2, 32'h0000_00F1});
        vecs.push_back('{0, 1'b1, 1'b0, 8'h06, 2'b10, 32'h0,         32'h0, 1'b1, 32'h0,         4'b0000, 1, 32'h1234_0000});
        vecs.push_back('{0, 1'b1, 1'b0, 8'h08, 2'b00, 32'hFFFF_FF80, 32'h0, 1'b0, 32'h0,         4'b0100, 2, 32'h0000_0071});
        vecs.push_back('{1, 1'b1, 1'b0, 8'h00, 2'b10, 32'hCAFE_F00D, 32'h0, 1'b0, 32'h0,         4'b0001, 0, 32'hCAFE_F00D});
        vecs.push_back('{1, 1'b1, 1'b0, 8'h01, 2'b01, 32'h0000_FFFF, 32'h0, 1'b1, 32'h0,         4'b0000, 0, 32'hCAFE_F00D});
        vecs.push_back('{1, 1'b0, 1'b1, 8'h02, 2'b01, 32'h0,         32'h0, 1'b0, 32'hCAFE_F00D, 4'b0000, 0, 32'hCAFE_F00D});

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ack", {ack0, ack3}, 2'b00);
        chk("rst_err", {err0, err3}, 2'b00);
        chk("rst_rdata", {rdata0, rdata3}, 64'h0);
        chk("rst_pulse", {pulse0, pulse3}, 8'h00);
        chk("rst_regs0", regs0, {32'h0, c_RV[95:0]});
        chk("rst_regs3", regs3, {32'h0, c_RV[95:0]});
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            do_txn(vecs[i], $sformatf("v%0d", i));
        end

        // Standalone hardware set on the W1C register of both instances.
        @(negedge clk);
        hw_set = {32'h0, 32'h0000_0100, 64'h0};
        @(negedge clk);
        hw_set = '0;
        @(negedge clk);
        chk("hwset_reg2_d0", get_reg(0, 2), 32'h0000_0171);
        chk("hwset_reg2_d3", get_reg(1, 2), 32'h0000_01FF);

        // Reset in the middle of a waited write: no ack, storage back to reset values.
        @(negedge clk);
        wen = 1'b1; addr = 8'h04; width = 2'b10; wdata = 32'h0000_0055; sel3 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle_bus();
        chk("rstmid_reg1_d3", get_reg(1, 1), 32'hA5A5_0000);
        chk("rstmid_reg0_d0", get_reg(0, 0), 32'h1122_3344);
        chk("rstmid_reg2_d0", get_reg(0, 2), 32'h0000_00FF);
        watch_no_ack(1, "rstmid_noack");
        do_txn('{1, 1'b0, 1'b1, 8'h04, 2'b10, 32'h0, 32'h0, 1'b0, 32'hA5A5_0000, 4'b0000, 1, 32'hA5A5_0000},
               "after_rst");

        // Select dropped during wait: no ack, but the write stays committed.
        @(negedge clk);
        wen = 1'b1; addr = 8'h04; width = 2'b10; wdata = 32'h0000_0077; sel3 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        idle_bus();
        watch_no_ack(1, "seldrop_noack");
        chk("seldrop_reg1", get_reg(1, 1), 32'h0000_0077);
        do_txn('{1, 1'b0, 1'b1, 8'h04, 2'b10, 32'h0, 32'h0, 1'b0, 32'h0000_0077, 4'b0000, 1, 32'h0000_0077},
               "after_drop");

        chk("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
